// File: rtl/gpr_snapshot_ctrl.sv
// -----------------------------------------------------------------------------
// gpr_snapshot_ctrl
//
// Copies the whole general-purpose register file into a ring of BRAM snapshot
// frames whenever a rising edge is seen on snap_req. Each frame is 256 bytes:
// word 0 is a header {16'hC0DE, snap_cnt}, words 1..32 are GPR 0..31, and
// words 33..63 are left untouched.
//
// Handshake: snap_req is edge-triggered. One edge while idle starts a
// snapshot. One further edge while a snapshot is in flight is held as
// "pending" and runs back-to-back. Any edge beyond that is lost and sets the
// sticky drop_err, which only drop_clr clears (a same-cycle drop wins).
// snap_ack pulses for one cycle as each frame completes.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   snap_req          snapshot request (rising edge)
//   drop_clr          synchronous clear of drop_err
//   busy              high from HDR through DONE of every frame
//   snap_ack          one-cycle pulse per completed frame
//   drop_err          sticky lost-request flag
//   frame_idx         frame the next snapshot writes
//   snap_cnt          completed snapshot count (wraps)
//   gpr_raddr         register heap debug read address
//   gpr_rdata         combinational register heap read data
//   ram_clk, ram_rst  BRAM clock / active-high reset
//   ram_en, ram_we    BRAM enable / byte write enables
//   ram_addr          BRAM byte address
//   ram_wr_data       BRAM write data
//   dbg_state         current FSM state (0 IDLE, 1 HDR, 2 DUMP, 3 DONE)
// -----------------------------------------------------------------------------
module gpr_snapshot_ctrl #(
    parameter int          GPR_BIT   = 32,
    parameter int          GPR_ADR   = 5,
    parameter int          FRAMES    = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       snap_req,
    input  logic                       drop_clr,
    output logic                       busy,
    output logic                       snap_ack,
    output logic                       drop_err,
    output logic [$clog2(FRAMES)-1:0]  frame_idx,
    output logic [15:0]                snap_cnt,
    output logic [GPR_ADR-1:0]         gpr_raddr,
    input  logic [GPR_BIT-1:0]         gpr_rdata,
    output logic                       ram_clk,
    output logic                       ram_rst,
    output logic                       ram_en,
    output logic [3:0]                 ram_we,
    output logic [31:0]                ram_addr,
    output logic [GPR_BIT-1:0]         ram_wr_data,
    output logic [1:0]                 dbg_state
);

    localparam int FI_W = $clog2(FRAMES);
    localparam logic [GPR_ADR-1:0] WC_LAST = {GPR_ADR{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DUMP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [GPR_ADR-1:0] wc_q, wc_d;
    logic               req_q;
    logic               pend_q, pend_d;
    logic               drop_q, drop_d;
    logic               drop_set;
    logic [FI_W-1:0]    fi_q, fi_d;
    logic [15:0]        cnt_q, cnt_d;

    logic               en_q, en_d;
    logic [3:0]         we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [GPR_ADR-1:0] raddr_q, raddr_d;
    logic               ack_q, ack_d;
    logic               busy_q, busy_d;

    logic               req_edge;
    logic [31:0]        frame_base;

    assign req_edge = snap_req & ~req_q;

    // Base of the frame the next state will write. Uses the post-increment
    // frame index so the HDR address after DONE already points at the new frame.
    assign frame_base = BASE_ADDR + (32'(fi_d) << 8);

    always_comb begin
        state_d  = state_q;
        wc_d     = wc_q;
        pend_d   = pend_q;
        drop_set = 1'b0;
        fi_d     = fi_q;
        cnt_d    = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (req_edge) begin
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                state_d = S_DUMP;
                wc_d    = '0;
                if (req_edge) begin
                    if (pend_q) drop_set = 1'b1;
                    else        pend_d   = 1'b1;
                end
            end
            S_DUMP: begin
                if (wc_q == WC_LAST) begin
                    state_d = S_DONE;
                end else begin
                    wc_d = wc_q + GPR_ADR'(1);
                end
                if (req_edge) begin
                    if (pend_q) drop_set = 1'b1;
                    else        pend_d   = 1'b1;
                end
            end
            S_DONE: begin
                fi_d   = fi_q + FI_W'(1);
                cnt_d  = cnt_q + 16'd1;
                wc_d   = '0;
                pend_d = 1'b0;
                // An edge landing in DONE is a busy-time request: with nothing
                // pending it is taken directly as the next frame, otherwise it
                // is lost.
                if (req_edge && pend_q) begin
                    drop_set = 1'b1;
                end
                if (pend_q || req_edge) begin
                    state_d = S_HDR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered outputs are derived from the next state so they line up
        // with the state register cycle-for-cycle.
        en_d    = (state_d == S_HDR) || (state_d == S_DUMP);
        we_d    = en_d ? 4'hF : 4'h0;
        raddr_d = (state_d == S_DUMP) ? wc_d : '0;
        ack_d   = (state_d == S_DONE);
        busy_d  = (state_d != S_IDLE);
        case (state_d)
            S_HDR:   addr_d = frame_base;
            S_DUMP:  addr_d = frame_base + ((32'(wc_d) + 32'd1) << 2);
            default: addr_d = 32'h0;
        endcase

        if (drop_set)      drop_d = 1'b1;
        else if (drop_clr) drop_d = 1'b0;
        else               drop_d = drop_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wc_q    <= '0;
            req_q   <= 1'b1;   // a request held through reset is not an edge
            pend_q  <= 1'b0;
            drop_q  <= 1'b0;
            fi_q    <= '0;
            cnt_q   <= 16'd0;
            en_q    <= 1'b0;
            we_q    <= 4'h0;
            addr_q  <= 32'h0;
            raddr_q <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wc_q    <= wc_d;
            req_q   <= snap_req;
            pend_q  <= pend_d;
            drop_q  <= drop_d;
            fi_q    <= fi_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            raddr_q <= raddr_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    assign busy        = busy_q;
    assign snap_ack    = ack_q;
    assign drop_err    = drop_q;
    assign frame_idx   = fi_q;
    assign snap_cnt    = cnt_q;
    assign gpr_raddr   = raddr_q;
    assign ram_clk     = clk;
    assign ram_rst     = ~rst_n;
    assign ram_en      = en_q;
    assign ram_we      = we_q;
    assign ram_addr    = addr_q;
    // Header only during HDR; otherwise the live register value passes
    // straight through so each word reflects the register at its write cycle.
    assign ram_wr_data = (state_q == S_HDR) ? GPR_BIT'({16'hC0DE, cnt_q}) : gpr_rdata;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_gpr_snapshot_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gpr_snapshot_ctrl
//
// Directed bench for gpr_snapshot_ctrl: reset hold, single snapshot, ring
// wrap, back-to-back queuing, request drop / clear and mid-dump reset.
// A GPR array model drives gpr_rdata; BRAM writes are captured into a word
// memory and header writes into queues, then compared against hand-computed
// values.
// -----------------------------------------------------------------------------
module tb_gpr_snapshot_ctrl;

    logic        clk;
    logic        rst_n;
    logic        snap_req;
    logic        drop_clr;
    logic        busy;
    logic        snap_ack;
    logic        drop_err;
    logic [1:0]  frame_idx;
    logic [15:0] snap_cnt;
    logic [4:0]  gpr_raddr;
    logic [31:0] gpr_rdata;
    logic        ram_clk;
    logic        ram_rst;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wr_data;
    logic [1:0]  dbg_state;

    logic [31:0] gpr [0:31];
    logic [31:0] mem [0:255];
    logic [31:0] hdr_addr_q[$];
    logic [31:0] hdr_data_q[$];

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int ack_cnt = 0;
    int busy_cyc = 0;
    int busy_fall = 0;
    logic busy_prev = 1'b0;

    gpr_snapshot_ctrl #(
        .GPR_BIT   (32),
        .GPR_ADR   (5),
        .FRAMES    (4),
        .BASE_ADDR (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .snap_req    (snap_req),
        .drop_clr    (drop_clr),
        .busy        (busy),
        .snap_ack    (snap_ack),
        .drop_err    (drop_err),
        .frame_idx   (frame_idx),
        .snap_cnt    (snap_cnt),
        .gpr_raddr   (gpr_raddr),
        .gpr_rdata   (gpr_rdata),
        .ram_clk     (ram_clk),
        .ram_rst     (ram_rst),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wr_data (ram_wr_data),
        .dbg_state   (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign gpr_rdata = gpr[gpr_raddr];

    // Monitor: sample away from the active edge
    always @(negedge clk) begin
        if (ram_en && ram_we == 4'hF) begin
            mem[ram_addr[9:2]] = ram_wr_data;
            wr_cnt = wr_cnt + 1;
            if (ram_addr[7:0] == 8'h00) begin
                hdr_addr_q.push_back(ram_addr);
                hdr_data_q.push_back(ram_wr_data);
            end
        end
        if (snap_ack) ack_cnt = ack_cnt + 1;
        if (busy) busy_cyc = busy_cyc + 1;
        if (busy_prev && !busy) busy_fall = busy_fall + 1;
        busy_prev = busy;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise snap_req for one cycle; returns just after the detecting edge.
    task automatic pulse_req();
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
    endtask

    task automatic wait_ack(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n = n + 1;
        end while (!snap_ack && n < 200);
        chk(tag, 32'(snap_ack), 32'd1);
    endtask

    initial begin
        int lat;
        int bad;
        int w0, a0, b0, f0, h0;

        for (int k = 0; k < 32; k++) gpr[k] = 32'h1000 + 32'(k);
        rst_n    = 1'b0;
        snap_req = 1'b1;
        drop_clr = 1'b0;

        // ---- Reset with request held high ----
        repeat (3) tick();
        chk("rst_ram_rst", 32'(ram_rst), 32'd1);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        w0 = wr_cnt;
        rst_n = 1'b1;
        repeat (10) tick();
        chk("hold_ram_rst", 32'(ram_rst), 32'd0);
        chk("hold_ram_en", 32'(ram_en), 32'd0);
        chk("hold_busy", 32'(busy), 32'd0);
        chk("hold_writes", 32'(wr_cnt - w0), 32'd0);
        chk("hold_snap_cnt", 32'(snap_cnt), 32'd0);
        chk("hold_frame_idx", 32'(frame_idx), 32'd0);
        chk("hold_drop_err", 32'(drop_err), 32'd0);
        chk("hold_ram_addr", ram_addr, 32'd0);
        snap_req = 1'b0;
        repeat (2) tick();

        // ---- Single snapshot ----
        w0 = wr_cnt; a0 = ack_cnt; b0 = busy_cyc;
        pulse_req();
        chk("hdr_state", 32'(dbg_state), 32'd1);
        chk("hdr_busy", 32'(busy), 32'd1);
        chk("hdr_addr", ram_addr, 32'h0);
        chk("hdr_we", 32'(ram_we), 32'hF);
        chk("hdr_data", ram_wr_data, 32'hC0DE_0000);
        lat = 0;
        while (!snap_ack && lat < 100) begin
            tick();
            lat = lat + 1;
        end
        chk("ack_latency", 32'(lat), 32'd33);
        repeat (3) tick();
        chk("single_busy_cycles", 32'(busy_cyc - b0), 32'd34);
        chk("single_acks", 32'(ack_cnt - a0), 32'd1);
        chk("single_writes", 32'(wr_cnt - w0), 32'd33);
        chk("single_word0", mem[0], 32'hC0DE_0000);
        bad = 0;
        for (int k = 0; k < 32; k++) if (mem[k + 1] !== 32'h1000 + 32'(k)) bad++;
        chk("single_gpr_words", 32'(bad), 32'd0);
        chk("single_frame_idx", 32'(frame_idx), 32'd1);
        chk("single_snap_cnt", 32'(snap_cnt), 32'd1);

        // ---- Ring wrap: four more snapshots ----
        h0 = hdr_addr_q.size();
        for (int i = 1; i <= 4; i++) begin
            if (i == 4) for (int k = 0; k < 32; k++) gpr[k] = 32'hA500_0000 + 32'(k);
            pulse_req();
            wait_ack("ring_ack");
            repeat (2) tick();
        end
        chk("ring_hdr_addr1", hdr_addr_q[h0 + 0], 32'h100);
        chk("ring_hdr_addr2", hdr_addr_q[h0 + 1], 32'h200);
        chk("ring_hdr_addr3", hdr_addr_q[h0 + 2], 32'h300);
        chk("ring_hdr_addr4", hdr_addr_q[h0 + 3], 32'h000);
        chk("ring_hdr_data1", hdr_data_q[h0 + 0], 32'hC0DE_0001);
        chk("ring_hdr_data4", hdr_data_q[h0 + 3], 32'hC0DE_0004);
        chk("ring_frame3_last", mem[8'hE0], 32'h101F);
        chk("ring_word0", mem[0], 32'hC0DE_0004);
        bad = 0;
        for (int k = 0; k < 32; k++) if (mem[k + 1] !== 32'hA500_0000 + 32'(k)) bad++;
        chk("ring_frame0_words", 32'(bad), 32'd0);
        chk("ring_frame_idx", 32'(frame_idx), 32'd1);
        chk("ring_snap_cnt", 32'(snap_cnt), 32'd5);

        // ---- Queuing: second edge five cycles into the dump ----
        h0 = hdr_addr_q.size(); b0 = busy_cyc; f0 = busy_fall;
        pulse_req();
        repeat (6) tick();
        pulse_req();
        chk("queue_drop_err", 32'(drop_err), 32'd0);
        wait_ack("queue_ack1");
        tick();
        chk("queue_hdr_direct", 32'(dbg_state), 32'd1);
        wait_ack("queue_ack2");
        repeat (3) tick();
        chk("queue_busy_cycles", 32'(busy_cyc - b0), 32'd68);
        chk("queue_busy_falls", 32'(busy_fall - f0), 32'd1);
        chk("queue_drop_err_end", 32'(drop_err), 32'd0);
        chk("queue_hdr_addr1", hdr_addr_q[h0 + 0], 32'h100);
        chk("queue_hdr_addr2", hdr_addr_q[h0 + 1], 32'h200);
        chk("queue_hdr_data2", hdr_data_q[h0 + 1], 32'hC0DE_0006);
        chk("queue_snap_cnt", 32'(snap_cnt), 32'd7);
        chk("queue_frame_idx", 32'(frame_idx), 32'd3);

        // ---- Drop: third edge during the first frame ----
        a0 = ack_cnt;
        pulse_req();
        repeat (3) tick();
        pulse_req();
        chk("drop_not_yet", 32'(drop_err), 32'd0);
        repeat (3) tick();
        pulse_req();
        chk("drop_set", 32'(drop_err), 32'd1);
        wait_ack("drop_ack1");
        wait_ack("drop_ack2");
        repeat (3) tick();
        chk("drop_acks", 32'(ack_cnt - a0), 32'd2);
        chk("drop_sticky", 32'(drop_err), 32'd1);
        chk("drop_idle", 32'(busy), 32'd0);
        chk("drop_snap_cnt", 32'(snap_cnt), 32'd9);
        chk("drop_frame_idx", 32'(frame_idx), 32'd1);
        drop_clr = 1'b1;
        tick();
        drop_clr = 1'b0;
        chk("drop_cleared", 32'(drop_err), 32'd0);

        // ---- Mid-dump asynchronous reset ----
        pulse_req();
        lat = 0;
        while (!(dbg_state == 2'd2 && gpr_raddr == 5'd10) && lat < 50) begin
            tick();
            lat = lat + 1;
        end
        chk("mid_reached_wc10", 32'(gpr_raddr), 32'd10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_ram_en", 32'(ram_en), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_frame_idx", 32'(frame_idx), 32'd0);
        chk("mid_snap_cnt", 32'(snap_cnt), 32'd0);
        chk("mid_ram_rst", 32'(ram_rst), 32'd1);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        h0 = hdr_addr_q.size();
        pulse_req();
        wait_ack("post_rst_ack");
        repeat (2) tick();
        chk("post_rst_hdr_addr", hdr_addr_q[h0], 32'h0);
        chk("post_rst_hdr_data", hdr_data_q[h0], 32'hC0DE_0000);
        chk("post_rst_frame_idx", 32'(frame_idx), 32'd1);
        chk("post_rst_snap_cnt", 32'(snap_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpr_snapshot_ctrl.md
# gpr_snapshot_ctrl

Sequencer that copies the full general-purpose register file into a BRAM ring of snapshot frames on request. It sits between the ID-stage register heap and the block-RAM port. It drives the heap's debug read address and the BRAM write port, and returns a per-snapshot acknowledge. Each frame holds a header word followed by all 32 GPRs, so the host can read several consecutive snapshots and order them by sequence number.

## Interface
Parameters:
- GPR_BIT, 32, register and BRAM data width
- GPR_ADR, 5, register address width
- FRAMES, 4, number of snapshot frames in the ring; power of two, 2..16
- BASE_ADDR, 32'h0000_0000, byte address of frame 0; must be 256-byte aligned

Ports:
- clk  in  1  system clock; all logic on posedge clk
- rst_n  in  1  asynchronous, active-low reset
- snap_req  in  1  snapshot request; rising edge triggers one snapshot
- drop_clr  in  1  synchronous clear of drop_err
- busy  out  1  high while a snapshot is in progress (state != IDLE)
- snap_ack  out  1  one-cycle pulse when a frame is complete
- drop_err  out  1  sticky flag: a request was lost
- frame_idx  out  $clog2(FRAMES)  frame that the next snapshot writes
- snap_cnt  out  16  count of completed snapshots, wraps at 16'hFFFF to 0
- gpr_raddr  out  GPR_ADR  read address into the register heap
- gpr_rdata  in  GPR_BIT  combinational read data for gpr_raddr
- ram_clk  out  1  equals clk
- ram_rst  out  1  equals ~rst_n
- ram_en  out  1  BRAM enable
- ram_we  out  4  BRAM byte write enables
- ram_addr  out  32  BRAM byte address
- ram_wr_data  out  GPR_BIT  BRAM write data

## Operation
- Edge detection: req_d <= snap_req each cycle; edge = snap_req & ~req_d.
  - req_d resets to 1, so a request held high through reset does not trigger.
- FSM states: IDLE, HDR, DUMP, DONE.
  - IDLE: on edge, go to HDR; otherwise stay.
  - HDR (1 cycle): ram_en=1, ram_we=4'hF, ram_addr = frame base, ram_wr_data = {16'hC0DE, snap_cnt}.
  - DUMP (32 cycles): word counter wc runs 0..31; gpr_raddr=wc, ram_addr = frame base + 4*(wc+1), ram_wr_data = gpr_rdata. After wc==31, go to DONE.
  - DONE (1 cycle): ram_en=0, ram_we=0, snap_ack=1.
    - frame_idx <= frame_idx+1, wrapping modulo FRAMES.
    - snap_cnt <= snap_cnt+1.
    - If pending is set, clear it and go to HDR; else go to IDLE.
- Frame base = BASE_ADDR + frame_idx*256. The stride is 64 words; words 33..63 of each frame are never written.
- ram_en, ram_we, ram_addr, gpr_raddr, snap_ack and busy are registered. ram_wr_data is combinational: the header in HDR, gpr_rdata otherwise.
- Request queuing:
  - An edge while busy sets pending.
  - An edge while pending is already set sets drop_err; that request is lost.
  - An edge in DONE counts as busy.
- drop_err clears on drop_clr. If drop_clr and a new drop occur in the same cycle, the set wins.
- The header holds the pre-increment snap_cnt, so the first snapshot after reset has header 32'hC0DE_0000.
- GPR writes landing during DUMP are not blocked. Each frame word reflects the register value at the cycle that word is written.

## Timing
- Reset values: all outputs 0, state=IDLE, wc=0, pending=0, req_d=1.
- ram_rst=1 during reset; ram_clk follows clk.
- Latency: edge detected at posedge n; HDR is active in cycle n+1; DUMP runs cycles n+2..n+33; DONE (snap_ack=1) is cycle n+34.
- busy is high for 34 cycles, n+1..n+34.
- Back-to-back: with pending set, HDR follows DONE directly and busy stays high. No IDLE cycle occurs between frames.
- Wrap: frame_idx FRAMES-1 goes to 0. snap_cnt 16'hFFFF goes to 0 with no flag.
- Asynchronous reset mid-snapshot: all outputs drop immediately. The partially written frame is abandoned; the next snapshot writes frame 0 with header count 0.

## Test plan
- Single snapshot: load GPR k = 32'h1000+k, pulse snap_req -> 33 writes at 0x000..0x080. Word 0 = 32'hC0DE_0000, word k+1 = 32'h1000+k. snap_ack fires 34 cycles after the edge; frame_idx becomes 1; snap_cnt becomes 1.
- Ring wrap with FRAMES=4: five snapshots -> bases 0x000, 0x100, 0x200, 0x300, then 0x000 again. The fifth header is 32'hC0DE_0004.
- Queuing: second edge 5 cycles into a dump -> two consecutive frames, busy continuously high for 68 cycles, drop_err=0. A third edge during the first frame -> drop_err=1; drop_clr then clears it.
- Reset hold: snap_req held high through reset release -> no snapshot; ram_en stays 0.
- Mid-dump reset: assert rst_n=0 at DUMP wc=10 -> ram_en, busy and frame_idx are 0 immediately. A new request then writes to BASE_ADDR with header 32'hC0DE_0000.
